// File: rtl/decod_scan_if.sv
// Handshake and decoder-select bundle for decod_scan.
// DECOD_SCAN_MASK_EN adds the skip_mask_pad scan mask.
interface decod_scan_if;
  logic        start_pad;
  logic        mode_pad;
  logic [3:0]  addr_pad;
  logic        abort_pad;
  logic        a_pad, b_pad, c_pad, d_pad;
  logic        e_pad;
  logic        busy_pad;
  logic        done_pad;
`ifdef DECOD_SCAN_MASK_EN
  logic [15:0] skip_mask_pad;
`endif

  modport slave (
    input  start_pad, mode_pad, addr_pad, abort_pad,
`ifdef DECOD_SCAN_MASK_EN
    input  skip_mask_pad,
`endif
    output a_pad, b_pad, c_pad, d_pad, e_pad, busy_pad, done_pad
  );

  modport master (
    output start_pad, mode_pad, addr_pad, abort_pad,
`ifdef DECOD_SCAN_MASK_EN
    output skip_mask_pad,
`endif
    input  a_pad, b_pad, c_pad, d_pad, e_pad, busy_pad, done_pad
  );
endinterface

// File: rtl/decod_scan.sv
// Sequencer driving a 16-way decoder: code setup, enable strobe, hold, per code.
// Optional skip mask for scan mode under DECOD_SCAN_MASK_EN.
module decod_scan #(
  parameter int DWELL = 4,
  parameter int GAP   = 1
) (
  input  logic         clk_pad,
  input  logic         rst_pad,
  decod_scan_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  code, code_nxt;
  logic        mode, mode_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        e_q, done_q, busy_q;
  logic [15:0] mask;
  logic [4:0]  first, nxt;

`ifdef DECOD_SCAN_MASK_EN
  assign mask = bus.skip_mask_pad;
`else
  assign mask = '0;
`endif

  // {found, code}: lowest unmasked code at or above 'from'; from=16 finds nothing
  function automatic logic [4:0] next_code(input logic [4:0] from, input logic [15:0] m);
    logic [4:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--)
      if (5'(i) >= from && !m[i]) r = {1'b1, 4'(i)};
    return r;
  endfunction

  assign first = next_code(5'd0, mask);
  assign nxt   = next_code({1'b0, code} + 5'd1, mask);

  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    mode_nxt  = mode;
    cnt_nxt   = cnt;
    case (state)
      IDLE:
        if (bus.start_pad && !bus.abort_pad) begin
          mode_nxt = bus.mode_pad;
          if (!bus.mode_pad) begin
            code_nxt  = bus.addr_pad;
            state_nxt = SETUP;
          end else if (first[4]) begin
            code_nxt  = first[3:0];
            state_nxt = SETUP;
          end else begin
            state_nxt = DONE;
          end
        end
      SETUP:
        if (bus.abort_pad) state_nxt = IDLE;
        else begin
          cnt_nxt   = '0;
          state_nxt = STROBE;
        end
      STROBE:
        if (bus.abort_pad) state_nxt = IDLE;
        else if (cnt == 8'(DWELL - 1)) begin
          cnt_nxt   = '0;
          state_nxt = HOLD;
        end else cnt_nxt = cnt + 8'd1;
      HOLD:
        if (bus.abort_pad) state_nxt = IDLE;
        else if (cnt == 8'(GAP - 1)) begin
          // code only moves on the edge into SETUP, so selects never change under e
          if (!mode || !nxt[4]) state_nxt = DONE;
          else begin
            code_nxt  = nxt[3:0];
            state_nxt = SETUP;
          end
        end else cnt_nxt = cnt + 8'd1;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_pad or posedge rst_pad) begin
    if (rst_pad) begin
      state  <= IDLE;
      code   <= '0;
      mode   <= 1'b0;
      cnt    <= '0;
      e_q    <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      code   <= code_nxt;
      mode   <= mode_nxt;
      cnt    <= cnt_nxt;
      e_q    <= (state_nxt == STROBE);
      done_q <= (state_nxt == DONE);
      busy_q <= (state_nxt != IDLE);
    end
  end

  assign bus.a_pad    = code[3];
  assign bus.b_pad    = code[2];
  assign bus.c_pad    = code[1];
  assign bus.d_pad    = code[0];
  assign bus.e_pad    = e_q;
  assign bus.done_pad = done_q;
  assign bus.busy_pad = busy_q;
endmodule
